// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control FSM and its datapath.
// slave = the control unit, master = whoever drives instruction/handshake.
interface multicycle_control_if;
  logic [10:0] op;
  logic        zero;
  logic        mem_ack;
  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg2loc;
  logic        alu_src;
  logic        pc_src;
  logic [1:0]  alu_op;
  logic        exc;
  logic [2:0]  state;
  logic [15:0] instr_count;

  modport slave (
    input  op, zero, mem_ack,
    output pc_write, ir_write, reg_write, mem_read, mem_write,
           mem_to_reg, reg2loc, alu_src, pc_src, alu_op, exc, state, instr_count
  );

  modport master (
    output op, zero, mem_ack,
    input  pc_write, ir_write, reg_write, mem_read, mem_write,
           mem_to_reg, reg2loc, alu_src, pc_src, alu_op, exc, state, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM for a small LEGv8 subset (LDUR/STUR/CBZ/R-type).
// Opcode class is latched in DECODE so later states ignore op changes.
module multicycle_control (
  input logic clk,
  input logic reset,
  multicycle_control_if.slave bus
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_LDUR  = 3'd1;
  localparam logic [2:0] C_STUR  = 3'd2;
  localparam logic [2:0] C_CBZ   = 3'd3;
  localparam logic [2:0] C_RTYPE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  cls_q, cls_dec;
  logic        run;      // low from reset until the first edge after release
  logic        exc_q;
  logic        retire;
  logic [15:0] cnt;

  // classify the raw opcode
  always_comb begin
    cls_dec = C_NONE;
    if (bus.op == 11'b11111000010)         cls_dec = C_LDUR;
    else if (bus.op == 11'b11111000000)    cls_dec = C_STUR;
    else if (bus.op[10:3] == 8'b10110100)  cls_dec = C_CBZ;
    else if (bus.op == 11'b10001011000 || bus.op == 11'b11001011000 ||
             bus.op == 11'b10001010000 || bus.op == 11'b10101010000)
                                           cls_dec = C_RTYPE;
  end

  // next state and retirement detect
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (run && bus.mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        case (cls_dec)
          C_LDUR, C_STUR, C_RTYPE: state_d = S_EXEC;
          C_CBZ:                   state_d = S_BRANCH;
          default:                 state_d = S_HALT;
        endcase
      end
      S_EXEC:   state_d = (cls_q == C_RTYPE) ? S_WB : S_MEM;
      S_MEM: begin
        if (bus.mem_ack) begin
          if (cls_q == C_LDUR) state_d = S_WB;
          else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // control outputs; FETCH stays quiet until run so reset release is clean
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg2loc    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.pc_src     = 1'b0;
    bus.alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = run;
        if (run && bus.mem_ack) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        if (cls_q == C_RTYPE) bus.alu_op = 2'b10;
        else begin
          bus.alu_src = 1'b1;
          bus.reg2loc = (cls_q == C_STUR);
        end
      end
      S_MEM: begin
        bus.alu_src   = 1'b1;
        bus.mem_read  = (cls_q == C_LDUR);
        bus.mem_write = (cls_q == C_STUR);
        bus.reg2loc   = (cls_q == C_STUR);
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (cls_q == C_LDUR);
      end
      S_BRANCH: begin
        bus.reg2loc = 1'b1;
        bus.alu_op  = 2'b01;
        if (bus.zero) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // state, class latch, sticky exception and retirement counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      run     <= 1'b0;
      exc_q   <= 1'b0;
      cnt     <= 16'h0000;
    end else begin
      run     <= 1'b1;
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_dec;
      if (state_d == S_HALT)   exc_q <= 1'b1;
      if (retire)              cnt   <= cnt + 16'h0001;
    end
  end

  assign bus.exc         = exc_q;
  assign bus.state       = state_q;
  assign bus.instr_count = cnt;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // advance one cycle, apply mem_ack for it, leave time for outputs to settle
  task automatic go(input logic ack);
    @(posedge clk);
    #1 bus.mem_ack = ack;
    #1;
  endtask

  task automatic rst_seq();
    reset = 1'b0;
    #2;
    chk("rst_state", bus.state, 0);
    chk("rst_cnt", bus.instr_count, 0);
    chk("rst_exc", bus.exc, 0);
    chk("rst_quiet", {bus.mem_read, bus.mem_write, bus.pc_write, bus.ir_write, bus.reg_write}, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

  initial begin
    bus.op = 11'b10001011000;
    bus.zero = 1'b0;
    bus.mem_ack = 1'b0;
    rst_seq();

    // RTYPE ADD, ack on the first fetch cycle
    go(1);
    chk("rt_f_state", bus.state, 0);
    chk("rt_f_strobes", {bus.mem_read, bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write}, 5'b11100);
    go(1);
    chk("rt_d_state", bus.state, 1);
    chk("rt_d_quiet", {bus.mem_read, bus.ir_write, bus.pc_write, bus.reg_write}, 0);
    go(1);
    chk("rt_e_state", bus.state, 2);
    chk("rt_e_alu", {bus.alu_op, bus.alu_src, bus.reg_write}, 4'b1000);
    go(0);
    chk("rt_w_state", bus.state, 4);
    chk("rt_w_ctl", {bus.reg_write, bus.mem_to_reg}, 2'b10);
    go(0);
    chk("rt_done_state", bus.state, 0);
    chk("rt_cnt", bus.instr_count, 1);

    // LDUR with two cycles of ack delay in MEM; op changes after DECODE
    bus.op = 11'b11111000010;
    go(1);
    go(0);
    chk("ld_d_state", bus.state, 1);
    go(0);
    bus.op = 11'b10001011000;
    chk("ld_e_ctl", {bus.alu_src, bus.alu_op}, 3'b100);
    for (int i = 0; i < 3; i++) begin
      go(i == 2);
      chk("ld_m_state", bus.state, 3);
      chk("ld_m_rw", {bus.mem_read, bus.mem_write, bus.alu_src, bus.alu_op}, 5'b10100);
    end
    go(0);
    chk("ld_w_ctl", {bus.state, bus.reg_write, bus.mem_to_reg}, {3'd4, 2'b11});
    go(0);
    chk("ld_cnt", {bus.state, bus.instr_count}, {3'd0, 16'd2});

    // CBZ taken, with one fetch wait cycle
    bus.op = 11'b10110100101;
    go(0);
    chk("cbz_fwait", {bus.state, bus.mem_read, bus.ir_write, bus.pc_write}, {3'd0, 3'b100});
    go(1);
    go(0);
    bus.zero = 1'b1;
    go(0);
    chk("cbz1_b", {bus.state, bus.reg2loc, bus.alu_op, bus.pc_write, bus.pc_src}, {3'd5, 5'b10111});
    go(0);
    chk("cbz1_cnt", bus.instr_count, 3);

    // CBZ not taken
    bus.op = 11'b10110100000;
    go(1);
    go(0);
    bus.zero = 1'b0;
    go(0);
    chk("cbz0_b", {bus.state, bus.reg2loc, bus.alu_op, bus.pc_write, bus.pc_src}, {3'd5, 5'b10100});
    go(0);
    chk("cbz0_cnt", bus.instr_count, 4);

    // STUR completes normally
    bus.op = 11'b11111000000;
    go(1);
    go(0);
    go(0);
    chk("st_e_ctl", {bus.state, bus.reg2loc, bus.alu_src, bus.alu_op}, {3'd2, 4'b1100});
    go(1);
    chk("st_m_ctl", {bus.state, bus.mem_read, bus.mem_write, bus.reg2loc}, {3'd3, 3'b011});
    go(0);
    chk("st_cnt", {bus.state, bus.instr_count}, {3'd0, 16'd5});

    // STUR abandoned by reset while the MEM request is pending
    go(1);
    go(0);
    go(0);
    go(0);
    chk("st_pend", {bus.state, bus.mem_write}, {3'd3, 1'b1});
    #1 reset = 1'b0;
    #1;
    chk("st_rst_async", {bus.state, bus.mem_write, bus.mem_read}, {3'd0, 2'b00});
    chk("st_rst_cnt", bus.instr_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // invalid opcode goes to HALT and stays there
    bus.op = 11'b10101010101;
    go(1);
    go(0);
    chk("bad_d", {bus.state, bus.exc}, {3'd1, 1'b0});
    go(0);
    chk("bad_halt", {bus.state, bus.exc}, {3'd6, 1'b1});
    for (int i = 0; i < 20; i++) begin
      go(i[0]);
      chk("halt_quiet", {bus.state, bus.exc, bus.mem_read, bus.mem_write, bus.pc_write,
                         bus.ir_write, bus.reg_write, bus.alu_src, bus.alu_op},
          {3'd6, 1'b1, 8'd0});
    end
    rst_seq();

    // counter wrap: preload to FFFF, then one CBZ retirement
    go(0);
    force dut.cnt = 16'hFFFF;
    #1 release dut.cnt;
    #1;
    chk("wrap_preload", bus.instr_count, 16'hFFFF);
    bus.op = 11'b10110100000;
    go(1);
    go(0);
    go(0);
    chk("wrap_pre_ret", bus.instr_count, 16'hFFFF);
    go(0);
    chk("wrap", {bus.state, bus.instr_count}, {3'd0, 16'h0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
